display_digit_sched: RTL and testbench

- Frame-synchronous scheduler that feeds the VGA text overlay with the BCD digits it draws.
- Temperature digits: tens and units. Setpoint digits: hundreds, tens and units.
- On each frame-start pulse it snapshots the binary temperature and setpoint and converts both to BCD with a sequential double-dabble.
- All five digit registers are committed in a single cycle, so the overlay never shows a half-updated value within a frame.

---
 rtl/display_digit_sched.sv | 139 +++++++++++++
 tb/tb_display_digit_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/display_digit_sched.sv
// Frame-synchronous BCD digit scheduler for the VGA text overlay.
// On a frame-start pulse it snapshots the temperature and setpoint, converts
// both with an 8-step sequential double-dabble, and then commits all five
// digits in one cycle. The overlay therefore never sees a half-updated value.
module display_digit_sched #(
  parameter int unsigned TEMP_MAX   = 99,
  parameter int unsigned CONV_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       freeze,
  input  logic [7:0] temp_bin,
  input  logic [7:0] setp_bin,
  output logic [3:0] registrotd,
  output logic [3:0] registrotu,
  output logic [3:0] registrosc,
  output logic [3:0] registrosd,
  output logic [3:0] registrosu,
  output logic       busy,
  output logic       upd_done,
  output logic       temp_ovf,
  output logic       overrun
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [3:0] LastStep = 4'(CONV_STEPS - 1);

  logic [1:0]  state;
  logic [3:0]  step;
  logic [7:0]  temp_sh;
  logic [7:0]  setp_sh;
  logic [7:0]  temp_cap;
  logic [11:0] temp_bcd;
  logic [11:0] setp_bcd;

  logic [11:0] temp_adj;
  logic [11:0] setp_adj;
  logic [19:0] temp_shift;
  logic [19:0] setp_shift;
  logic        start_req;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [11:0] dab_adj(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // One double-dabble iteration for both operands: correct, then shift left.
  always_comb begin
    temp_adj   = dab_adj(temp_bcd);
    setp_adj   = dab_adj(setp_bcd);
    temp_shift = {temp_adj[10:0], temp_sh, 1'b0};
    setp_shift = {setp_adj[10:0], setp_sh, 1'b0};
    start_req  = frame_start && !freeze;
  end

  assign busy = (state != IDLE);

  // Sticky overrun: a live frame_start while a conversion is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (start_req && busy) begin
      overrun <= 1'b1;
    end
  end

  // Conversion FSM: capture, iterate, then commit all digits together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      temp_sh    <= '0;
      setp_sh    <= '0;
      temp_cap   <= '0;
      temp_bcd   <= '0;
      setp_bcd   <= '0;
      registrotd <= '0;
      registrotu <= '0;
      registrosc <= '0;
      registrosd <= '0;
      registrosu <= '0;
      temp_ovf   <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            temp_sh  <= temp_bin;
            temp_cap <= temp_bin;
            setp_sh  <= setp_bin;
            temp_bcd <= '0;
            setp_bcd <= '0;
            step     <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          {temp_bcd, temp_sh} <= temp_shift;
          {setp_bcd, setp_sh} <= setp_shift;
          step                <= step + 4'd1;
          if (step == LastStep) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          registrosc <= setp_bcd[11:8];
          registrosd <= setp_bcd[7:4];
          registrosu <= setp_bcd[3:0];
          // Saturate on the captured binary value so TEMP_MAX may be any limit.
          if (32'(temp_cap) > TEMP_MAX) begin
            registrotd <= 4'd9;
            registrotu <= 4'd9;
            temp_ovf   <= 1'b1;
          end else begin
            registrotd <= temp_bcd[7:4];
            registrotu <= temp_bcd[3:0];
            temp_ovf   <= 1'b0;
          end
          upd_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_digit_sched.sv
// Directed plus randomized bench for display_digit_sched. Expected digits come
// from decimal arithmetic on the applied values, not from any BCD algorithm.
module tb_display_digit_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       freeze;
  logic [7:0] temp_bin;
  logic [7:0] setp_bin;
  logic [3:0] registrotd, registrotu, registrosc, registrosd, registrosu;
  logic       busy, upd_done, temp_ovf, overrun;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of what the display should currently show.
  int exp_td, exp_tu, exp_sc, exp_sd, exp_su;
  int exp_ovf, exp_ovr;

  display_digit_sched dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .freeze     (freeze),
    .temp_bin   (temp_bin),
    .setp_bin   (setp_bin),
    .registrotd (registrotd),
    .registrotu (registrotu),
    .registrosc (registrosc),
    .registrosd (registrosd),
    .registrosu (registrosu),
    .busy       (busy),
    .upd_done   (upd_done),
    .temp_ovf   (temp_ovf),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".td"}, 32'(registrotd), 32'(exp_td));
    chk({tag, ".tu"}, 32'(registrotu), 32'(exp_tu));
    chk({tag, ".sc"}, 32'(registrosc), 32'(exp_sc));
    chk({tag, ".sd"}, 32'(registrosd), 32'(exp_sd));
    chk({tag, ".su"}, 32'(registrosu), 32'(exp_su));
    chk({tag, ".ovf"}, 32'(temp_ovf), 32'(exp_ovf));
    chk({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic model_reset();
    exp_td = 0; exp_tu = 0; exp_sc = 0; exp_sd = 0; exp_su = 0;
    exp_ovf = 0; exp_ovr = 0;
  endtask

  task automatic model_commit(input int t, input int s);
    if (t > 99) begin
      exp_td = 9; exp_tu = 9; exp_ovf = 1;
    end else begin
      exp_td = t / 10; exp_tu = t % 10; exp_ovf = 0;
    end
    exp_sc = s / 100; exp_sd = (s / 10) % 10; exp_su = s % 10;
  endtask

  // Capture on edge k, optional extra pulses at k+4 and k+9, optional input
  // change at k+3; expects exactly one commit at k+9 with the captured values.
  task automatic run_frame(input int t, input int s, input bit extra, input bit mid,
                           input int t_mid, input string tag);
    temp_bin    = 8'(t);
    setp_bin    = 8'(s);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    chk({tag, ".upd0"}, 32'(upd_done), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      frame_start = extra && (i == 4 || i == 9);
      if (mid && i == 3) begin
        temp_bin = 8'(t_mid);
        setp_bin = 8'($urandom);
      end
      cyc();
      if (frame_start) exp_ovr = 1;
      frame_start = 1'b0;
      if (i < 9) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".upd"}, 32'(upd_done), 32'd0);
        check_all({tag, ".hold"});
      end else begin
        model_commit(t, s);
        chk({tag, ".busyc"}, 32'(busy), 32'd0);
        chk({tag, ".updc"}, 32'(upd_done), 32'd1);
        check_all({tag, ".commit"});
      end
    end
    cyc();
    chk({tag, ".upd_end"}, 32'(upd_done), 32'd0);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t, s;
    int tbl_t[6] = '{0, 9, 99, 100, 255, 42};
    int tbl_s[6] = '{0, 99, 100, 199, 200, 9};
    rst = 1'b1; frame_start = 1'b0; freeze = 1'b0; temp_bin = '0; setp_bin = '0;
    model_reset();
    cyc(); cyc();
    rst = 1'b0;
    check_all("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.upd", 32'(upd_done), 32'd0);

    run_frame(37, 255, 1'b0, 1'b0, 0, "basic");
    run_frame(150, 0, 1'b0, 1'b0, 0, "sat");
    run_frame(5, 0, 1'b0, 1'b0, 0, "unsat");
    for (int i = 0; i < 6; i++) run_frame(tbl_t[i], tbl_s[i], 1'b0, 1'b0, 0, "edge");

    // Overrun: pulses at k+4 and k+9, then a clean start at k+12.
    run_frame(12, 34, 1'b1, 1'b0, 0, "ovr");
    cyc();
    run_frame(88, 123, 1'b0, 1'b0, 0, "after_ovr");

    // Inputs moving during conversion must not leak into the result.
    run_frame(37, 100, 1'b0, 1'b1, 64, "midchg");

    // Reset mid-conversion at k+5.
    temp_bin = 8'd77; setp_bin = 8'd66; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 1; i < 5; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    check_all("midrst");
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.upd", 32'(upd_done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("midrst.noupd", 32'(upd_done), 32'd0);
    end
    run_frame(61, 207, 1'b0, 1'b0, 0, "postrst");

    // Freeze: pulses and new values must have no visible effect.
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      temp_bin = 8'($urandom); setp_bin = 8'($urandom); frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      cyc();
      chk("frz.busy", 32'(busy), 32'd0);
      chk("frz.upd", 32'(upd_done), 32'd0);
      check_all("frz");
    end
    freeze = 1'b0;
    run_frame(23, 45, 1'b0, 1'b0, 0, "unfrz");

    // Randomized frames, some with overrun pulses or mid-conversion changes.
    for (int n = 0; n < 20; n++) begin
      t = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 255));
      run_frame(t, s, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
